// File: rtl/matrix_dot_core.sv
// Single dot-product compute core: streams row A[ry][*] and column B[*][rx], writes C[ry][rx].
// Optional output clamping to the element range is enabled by defining MATRIX_CORE_SATURATE_EN.
module matrix_dot_core #(
  parameter int maxWidthLen = 4,
  parameter int sizeValue   = 8,
  parameter int CORE_ID     = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [2:0]                           index,
  input  logic [maxWidthLen-1:0]               rx,
  input  logic [maxWidthLen-1:0]               ry,
  input  logic [maxWidthLen-1:0]               sizen,
  output logic                                 rd_en,
  output logic [2*maxWidthLen-1:0]             a_addr,
  output logic [2*maxWidthLen-1:0]             b_addr,
  input  logic [sizeValue-1:0]                 a_data,
  input  logic [sizeValue-1:0]                 b_data,
  output logic                                 c_we,
  output logic [2*maxWidthLen-1:0]             c_addr,
  output logic [2*sizeValue+maxWidthLen-1:0]   c_data,
  output logic                                 rdy
);

  localparam int MW = maxWidthLen;
  localparam int SV = sizeValue;
  localparam int PW = 2 * SV;
  localparam int AW = 2 * SV + MW;
  localparam logic [2:0] CORE_IDX = 3'(CORE_ID);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

`ifdef MATRIX_CORE_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-SV+1){1'b0}}, {(SV-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-SV+1){1'b1}}, {(SV-1){1'b0}}};

  function automatic logic signed [AW-1:0] sat_fn(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX;
    end else if (v < SAT_MIN) begin
      r = SAT_MIN;
    end else begin
      r = v;
    end
    return r;
  endfunction
`endif

  state_t              state_r, state_nxt_s;
  logic [MW-1:0]       rx_r, rx_nxt_s;
  logic [MW-1:0]       ry_r, ry_nxt_s;
  logic [MW-1:0]       sizen_r, sizen_nxt_s;
  logic [MW-1:0]       k_r, k_nxt_s;
  logic signed [AW-1:0] acc_r, acc_nxt_s;
  logic                pend_r, pend_nxt_s;
  logic                rd_en_r, rd_en_nxt_s;
  logic [2*MW-1:0]     a_addr_r, a_addr_nxt_s;
  logic [2*MW-1:0]     b_addr_r, b_addr_nxt_s;
  logic                c_we_r, c_we_nxt_s;
  logic [2*MW-1:0]     c_addr_r, c_addr_nxt_s;
  logic signed [AW-1:0] c_data_r, c_data_nxt_s;
  logic                rdy_r, rdy_nxt_s;

  logic signed [PW-1:0] prod_s;
  logic signed [AW-1:0] acc_sum_s;
  logic                 accept_s;

  // Operand data arrives one cycle after each read strobe; pend_r marks those cycles.
  assign prod_s    = $signed(a_data) * $signed(b_data);
  assign acc_sum_s = acc_r + AW'(prod_s);
  assign accept_s  = start && (index == CORE_IDX);

  // Next-state and next-output decode for the fetch/accumulate/write sequence.
  always_comb begin
    state_nxt_s  = state_r;
    rx_nxt_s     = rx_r;
    ry_nxt_s     = ry_r;
    sizen_nxt_s  = sizen_r;
    k_nxt_s      = k_r;
    pend_nxt_s   = rd_en_r;
    rd_en_nxt_s  = 1'b0;
    a_addr_nxt_s = a_addr_r;
    b_addr_nxt_s = b_addr_r;
    c_we_nxt_s   = 1'b0;
    c_addr_nxt_s = c_addr_r;
    c_data_nxt_s = c_data_r;
    rdy_nxt_s    = rdy_r;
    if (pend_r) begin
      acc_nxt_s = acc_sum_s;
    end else begin
      acc_nxt_s = acc_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s  = ST_FETCH;
          rx_nxt_s     = rx;
          ry_nxt_s     = ry;
          sizen_nxt_s  = sizen;
          k_nxt_s      = {MW{1'b0}};
          acc_nxt_s    = {AW{1'b0}};
          rd_en_nxt_s  = 1'b1;
          a_addr_nxt_s = {ry, {MW{1'b0}}};
          b_addr_nxt_s = {{MW{1'b0}}, rx};
          rdy_nxt_s    = 1'b0;
        end else begin
          rdy_nxt_s    = 1'b1;
        end
      end
      ST_FETCH: begin
        // k_r holds the index currently on the bus; compare before incrementing so k never wraps.
        if (k_r == sizen_r) begin
          state_nxt_s  = ST_DRAIN;
        end else begin
          k_nxt_s      = k_r + {{(MW-1){1'b0}}, 1'b1};
          rd_en_nxt_s  = 1'b1;
          a_addr_nxt_s = {ry_r, k_r + {{(MW-1){1'b0}}, 1'b1}};
          b_addr_nxt_s = {k_r + {{(MW-1){1'b0}}, 1'b1}, rx_r};
        end
      end
      ST_DRAIN: begin
        state_nxt_s  = ST_WRITE;
        c_we_nxt_s   = 1'b1;
        c_addr_nxt_s = {ry_r, rx_r};
`ifdef MATRIX_CORE_SATURATE_EN
        c_data_nxt_s = sat_fn(acc_nxt_s);
`else
        c_data_nxt_s = acc_nxt_s;
`endif
      end
      ST_WRITE: begin
        state_nxt_s  = ST_IDLE;
        rdy_nxt_s    = 1'b1;
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        rdy_nxt_s    = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered output state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_r     <= {MW{1'b0}};
      ry_r     <= {MW{1'b0}};
      sizen_r  <= {MW{1'b0}};
      k_r      <= {MW{1'b0}};
      acc_r    <= {AW{1'b0}};
      pend_r   <= 1'b0;
      rd_en_r  <= 1'b0;
      a_addr_r <= {(2*MW){1'b0}};
      b_addr_r <= {(2*MW){1'b0}};
      c_we_r   <= 1'b0;
      c_addr_r <= {(2*MW){1'b0}};
      c_data_r <= {AW{1'b0}};
      rdy_r    <= 1'b1;
    end else begin
      rx_r     <= rx_nxt_s;
      ry_r     <= ry_nxt_s;
      sizen_r  <= sizen_nxt_s;
      k_r      <= k_nxt_s;
      acc_r    <= acc_nxt_s;
      pend_r   <= pend_nxt_s;
      rd_en_r  <= rd_en_nxt_s;
      a_addr_r <= a_addr_nxt_s;
      b_addr_r <= b_addr_nxt_s;
      c_we_r   <= c_we_nxt_s;
      c_addr_r <= c_addr_nxt_s;
      c_data_r <= c_data_nxt_s;
      rdy_r    <= rdy_nxt_s;
    end
  end

  assign rd_en  = rd_en_r;
  assign a_addr = a_addr_r;
  assign b_addr = b_addr_r;
  assign c_we   = c_we_r;
  assign c_addr = c_addr_r;
  assign c_data = c_data_r;
  assign rdy    = rdy_r;

endmodule

// File: doc/matrix_dot_core.md
Name: matrix_dot_core

Overview:
- One of five compute cores fed by the matrix dispatch planner.
- Accepts a (rx, ry) coordinate when the planner's startCore pulse arrives with an index equal to this core's CORE_ID.
- Computes the signed dot product C[ry][rx] = sum over k of A[ry][k]*B[k][rx], streaming operands from dedicated synchronous read ports, writes one result word, then raises rdy back to the planner.

Parameters:
maxWidthLen, 4, coordinate width; matrix side up to 2^maxWidthLen.
sizeValue, 8, signed element width of A and B.
CORE_ID, 0, core number 0..4 matched against the index input.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
start  input  1  planner startCore pulse.
index  input  3  planner core select; the core accepts only when index == CORE_ID.
rx  input  maxWidthLen  result column (B column).
ry  input  maxWidthLen  result row (A row).
sizen  input  maxWidthLen  inner dimension minus 1; k runs 0..sizen inclusive.
rd_en  output  1  operand read strobe for both ports.
a_addr  output  2*maxWidthLen  {ry,k}.
b_addr  output  2*maxWidthLen  {k,rx}.
a_data  input  sizeValue  signed A element, valid the cycle after rd_en.
b_data  input  sizeValue  signed B element, valid the cycle after rd_en.
c_we  output  1  result write strobe, one-cycle pulse.
c_addr  output  2*maxWidthLen  {ry,rx} of the result.
c_data  output  2*sizeValue+maxWidthLen  signed result.
rdy  output  1  high when idle and able to accept work; feeds the planner's rdyN.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, rdy=1, rd_en=0, c_we=0, addresses=0, c_data=0, accumulator=0, k=0. Reset mid-operation aborts the computation with no write.
- States:
  - IDLE: accept when start && index==CORE_ID. Latch rx, ry, sizen; k=0; acc=0; rdy goes 0 the next cycle. In the accept cycle itself rdy is still 1.
  - FETCH: each cycle drive rd_en=1, a_addr={ry,k}, b_addr={k,rx}; k++. Leave after issuing k==sizen, i.e. sizen+1 issue cycles.
  - DRAIN: one cycle to absorb the final read's data.
- Accumulate: acc += a_data*b_data (signed, full width) in every cycle following an rd_en=1 cycle, covering the FETCH cycles after the first plus the DRAIN cycle.
- WRITE: c_we=1 for one cycle, c_addr={ry,rx}, c_data=acc. Go to IDLE with rdy=1 on the next cycle.
- Latency: with accept at cycle 0, FETCH occupies cycles 1..sizen+1, DRAIN is cycle sizen+2, c_we is at cycle sizen+3, and rdy=1 from cycle sizen+4.
- Widths:
  - Product: 2*sizeValue signed.
  - Accumulator: 2*sizeValue+maxWidthLen, sufficient for 2^maxWidthLen products with no overflow.
- start with index!=CORE_ID: ignored.
- start while not IDLE: ignored; the in-flight job is unaffected and the new coordinate is dropped.
- Inputs rx, ry, sizen are sampled only in the accept cycle; later changes have no effect.
- c_data and c_addr hold their last values outside c_we pulses.
- sizen = 2^maxWidthLen-1 (maximum) must not wrap k; the FETCH exit compares k==sizen before incrementing.

Optional Feature:
- Macro: MATRIX_CORE_SATURATE_EN.
- When defined: c_data is the accumulator clamped to the signed sizeValue range (-2^(sizeValue-1) .. 2^(sizeValue-1)-1) and sign-extended to the port width. A matching result is narrowed without change; the accumulator stays full width internally.
- When undefined: c_data is the raw full-width accumulator.

Test Plan:
- 2x2 product, sizen=1, CORE_ID=0: A=[[1,2],[3,4]], B=[[5,6],[7,8]], start index=0 rx=1 ry=0 -> c_we at cycle 4, c_addr={0,1}, c_data=22; rdy low in cycles 1..4, high at cycle 5.
- sizen=0: A[2][0]=-3, B[0][3]=7, rx=3 ry=2 -> c_data=-21 at cycle 3; only one rd_en cycle.
- CORE_ID=2 core with start index=1 -> no rd_en, rdy stays 1. Then start index=2 -> accepted.
- Second start with matching index during FETCH -> ignored; exactly one c_we, carrying the first coordinate's result.
- rst driven low during FETCH -> rdy=1, rd_en=0 immediately; no c_we. A fresh start after release computes correctly.
- MATRIX_CORE_SATURATE_EN defined, sizeValue=8, sizen=1, A row [100,100], B column [100,100] -> c_data=127; without the macro -> 20000.
